hilo_muldiv_unit: RTL and testbench

- Iterative multiply/divide engine that produces the 64-bit result and write controls consumed by the HI/LO register pair.
- Accepts one operation at a time from the execute stage and computes it over DATA_W cycles (shift-add multiply, restoring divide).
- Presents exactly one write cycle per operation on WriteData/RegWriteH/RegWriteL/Op.
- Also handles MTHI/MTLO single-cycle moves and MADD/MSUB accumulate requests.

---
 rtl/hilo_muldiv_unit.sv | 179 +++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide engine feeding the HI/LO register pair: shift-add multiply,
// restoring divide, MADD/MSUB accumulate requests and MTHI/MTLO moves, one write cycle per op.
module hilo_muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [2:0]            MdOp,
    input  logic [DATA_W-1:0]     A,
    input  logic [DATA_W-1:0]     B,
    output logic                  Busy,
    output logic                  Done,
    output logic [2*DATA_W-1:0]   WriteData,
    output logic                  RegWriteH,
    output logic                  RegWriteL,
    output logic [1:0]            Op
);

    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [2:0] OP_MADD = 3'b100;
    localparam logic [2:0] OP_MSUB = 3'b101;
    localparam logic [2:0] OP_MTHI = 3'b110;
    localparam logic [2:0] OP_MTLO = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, FIX, WRITE} state_e;
    typedef enum logic [1:0] {HL_WRITE, HL_ADD, HL_SUB, HL_NOP} hl_op_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            mdop_q, mdop_d;
    logic [DATA_W-1:0]     dvsr_q, dvsr_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic                  neg_q, neg_d;
    logic                  rneg_q, rneg_d;
    logic                  div0_q, div0_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [2*DATA_W-1:0]   wdata_q, wdata_d;
    logic                  wrh_q, wrh_d;
    logic                  wrl_q, wrl_d;
    hl_op_e                hlop_q, hlop_d;

    // Operand magnitudes captured at start; signs are restored in FIX.
    logic                  signed_in;
    logic [DATA_W-1:0]     abs_a, abs_b;
    assign signed_in = MdOp[2] | ~MdOp[0];
    assign abs_a     = (signed_in && A[DATA_W-1]) ? -A : A;
    assign abs_b     = (signed_in && B[DATA_W-1]) ? -B : B;

    logic                  is_div_q;
    assign is_div_q = ~mdop_q[2] & mdop_q[1];

    // acc_q holds {high partial product, remaining multiplier} or {remainder, dividend/quotient}.
    logic [DATA_W:0]       mul_sum;
    logic [2*DATA_W-1:0]   mul_step;
    assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, dvsr_q} : '0);
    assign mul_step = {mul_sum, acc_q[DATA_W-1:1]};

    logic [DATA_W:0]       div_top;
    logic [DATA_W-1:0]     div_diff;
    logic                  div_ge;
    logic [2*DATA_W-1:0]   div_step;
    assign div_top  = acc_q[2*DATA_W-1:DATA_W-1];
    assign div_ge   = div_top >= {1'b0, dvsr_q};
    assign div_diff = div_top[DATA_W-1:0] - dvsr_q;
    assign div_step = {div_ge ? div_diff : div_top[DATA_W-1:0], acc_q[DATA_W-2:0], div_ge};

    // Divide by zero keeps the all-ones quotient regardless of the dividend's sign.
    logic [DATA_W-1:0]     rem_fix, quo_fix;
    logic [2*DATA_W-1:0]   prod_fix;
    assign rem_fix  = rneg_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
    assign quo_fix  = (neg_q && !div0_q) ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    assign prod_fix = neg_q ? -acc_q : acc_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        mdop_d  = mdop_q;
        dvsr_d  = dvsr_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        div0_d  = div0_q;
        busy_d  = (state_q != IDLE);
        done_d  = 1'b0;
        wdata_d = '0;
        wrh_d   = 1'b0;
        wrl_d   = 1'b0;
        hlop_d  = HL_NOP;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    mdop_d = MdOp;
                    if (MdOp[2:1] == 2'b11) begin
                        state_d = WRITE;
                        acc_d   = MdOp[0] ? {{DATA_W{1'b0}}, A} : {A, {DATA_W{1'b0}}};
                    end else begin
                        state_d = CALC;
                        cnt_d   = CNT_W'(DATA_W - 1);
                        dvsr_d  = abs_b;
                        acc_d   = {{DATA_W{1'b0}}, abs_a};
                        neg_d   = signed_in & (A[DATA_W-1] ^ B[DATA_W-1]);
                        rneg_d  = signed_in & A[DATA_W-1];
                        div0_d  = (B == '0);
                    end
                end
            end
            CALC: begin
                acc_d = is_div_q ? div_step : mul_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
                acc_d   = is_div_q ? {rem_fix, quo_fix} : prod_fix;
                state_d = WRITE;
            end
            WRITE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                wdata_d = acc_q;
                unique case (mdop_q)
                    OP_MADD: hlop_d = HL_ADD;
                    OP_MSUB: hlop_d = HL_SUB;
                    OP_MTHI: begin hlop_d = HL_WRITE; wrh_d = 1'b1; end
                    OP_MTLO: begin hlop_d = HL_WRITE; wrl_d = 1'b1; end
                    default: begin hlop_d = HL_WRITE; wrh_d = 1'b1; wrl_d = 1'b1; end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mdop_q  <= '0;
            dvsr_q  <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wdata_q <= '0;
            wrh_q   <= 1'b0;
            wrl_q   <= 1'b0;
            hlop_q  <= HL_NOP;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mdop_q  <= mdop_d;
            dvsr_q  <= dvsr_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            div0_q  <= div0_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wdata_q <= wdata_d;
            wrh_q   <= wrh_d;
            wrl_q   <= wrl_d;
            hlop_q  <= hlop_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign WriteData = wdata_q;
    assign RegWriteH = wrh_q;
    assign RegWriteL = wrl_q;
    assign Op        = hlop_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed vector table, hand sequences for
// accumulate/back-to-back/reset-abort, and random ops against an arithmetic reference model.
module tb_hilo_muldiv_unit;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic [2:0]  MdOp;
    logic [31:0] A, B;
    logic        Busy, Done, RegWriteH, RegWriteL;
    logic [63:0] WriteData;
    logic [1:0]  Op;

    int n_checks = 0;
    int n_fail   = 0;

    hilo_muldiv_unit #(.DATA_W(32)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .MdOp(MdOp), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .WriteData(WriteData),
        .RegWriteH(RegWriteH), .RegWriteL(RegWriteL), .Op(Op)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
        $fatal(1);
    end

    // HI/LO register consumer: applies Op on every edge, as the real register does.
    logic [63:0] hilo;
    logic        trk_load;
    always @(posedge Clk) begin
        if (trk_load) hilo <= 64'd10;
        else begin
            case (Op)
                2'd0: begin
                    if (RegWriteH) hilo[63:32] <= WriteData[63:32];
                    if (RegWriteL) hilo[31:0]  <= WriteData[31:0];
                end
                2'd1: hilo <= hilo + WriteData;
                2'd2: hilo <= hilo - WriteData;
                default: ;
            endcase
        end
    end

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] wd;
        logic        h;
        logic        l;
        logic [1:0]  hop;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference model straight from the arithmetic definition of each operation.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output vec_t v);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        v.name = "rand";
        v.op = op; v.a = a; v.b = b;
        v.h = 1'b1; v.l = 1'b1; v.hop = 2'd0;
        case (op)
            3'd0, 3'd4, 3'd5: v.wd = sa * sb;
            3'd1:             v.wd = ua * ub;
            3'd2: begin
                if (b == 32'd0) v.wd = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb; r = sa % sb;
                    qv = q; rv = r;
                    v.wd = {rv[31:0], qv[31:0]};
                end
            end
            3'd3: begin
                if (b == 32'd0) v.wd = {a, 32'hFFFF_FFFF};
                else begin
                    qv = ua / ub; rv = ua % ub;
                    v.wd = {rv[31:0], qv[31:0]};
                end
            end
            3'd6:    begin v.wd = {a, 32'b0}; v.l = 1'b0; end
            default: begin v.wd = {32'b0, a}; v.h = 1'b0; end
        endcase
        if (op == 3'd4) begin v.hop = 2'd1; v.h = 1'b0; v.l = 1'b0; end
        if (op == 3'd5) begin v.hop = 2'd2; v.h = 1'b0; v.l = 1'b0; end
    endfunction

    // Issues one op and watches every cycle until Done (bounded), then one cycle after.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] wd, output logic h, output logic l,
                          output logic [1:0] hop, output int lat,
                          output bit busy_ok, output bit op_ok, output bit post_ok);
        @(negedge Clk);
        Start = 1'b1; MdOp = op; A = a; B = b;
        @(posedge Clk); #1;
        Start = 1'b0;
        lat = -1; busy_ok = 1'b1; op_ok = 1'b1; post_ok = 1'b0;
        wd = '0; h = 1'b0; l = 1'b0; hop = 2'd3;
        for (int c = 1; c <= 60; c++) begin
            @(posedge Clk); #1;
            if (Busy !== 1'b1) busy_ok = 1'b0;
            if (Done === 1'b1) begin
                lat = c; wd = WriteData; h = RegWriteH; l = RegWriteL; hop = Op;
                break;
            end
            if (Op !== 2'd3 || RegWriteH !== 1'b0 || RegWriteL !== 1'b0) op_ok = 1'b0;
        end
        @(posedge Clk); #1;
        post_ok = (Done === 1'b0) && (Op === 2'd3) && (Busy === 1'b0) &&
                  (RegWriteH === 1'b0) && (RegWriteL === 1'b0);
    endtask

    task automatic apply_vec(input vec_t v);
        logic [63:0] wd;
        logic        h, l;
        logic [1:0]  hop;
        int          lat;
        bit          busy_ok, op_ok, post_ok;
        run_op(v.op, v.a, v.b, wd, h, l, hop, lat, busy_ok, op_ok, post_ok);
        check({v.name, "/latency"}, 64'(lat), (v.op[2:1] == 2'b11) ? 64'd1 : 64'd34);
        check({v.name, "/WriteData"}, wd, v.wd);
        check({v.name, "/RegWriteH,L"}, {62'b0, h, l}, {62'b0, v.h, v.l});
        check({v.name, "/Op"}, {62'b0, hop}, {62'b0, v.hop});
        check({v.name, "/busy_while_active"}, {63'b0, busy_ok}, 64'd1);
        check({v.name, "/op3_outside_write"}, {63'b0, op_ok}, 64'd1);
        check({v.name, "/idle_after_done"}, {63'b0, post_ok}, 64'd1);
    endtask

    vec_t        dir [10];
    vec_t        rv;
    logic [63:0] wd1, wd3;
    logic [3:0]  done_pat;
    bit          done_seen;
    logic [31:0] ra, rb;

    initial begin
        dir[0] = '{"multu_max",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b1, 2'd0};
        dir[1] = '{"mult_neg",   3'd0, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 1'b1, 1'b1, 2'd0};
        dir[2] = '{"mult_minsq", 3'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1, 1'b1, 2'd0};
        dir[3] = '{"div_neg",    3'd2, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b1, 2'd0};
        dir[4] = '{"div_negb",   3'd2, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b1, 1'b1, 2'd0};
        dir[5] = '{"divu_by0",   3'd3, 32'd7,         32'd0,         64'h0000_0007_FFFF_FFFF, 1'b1, 1'b1, 2'd0};
        dir[6] = '{"div_by0",    3'd2, 32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF, 1'b1, 1'b1, 2'd0};
        dir[7] = '{"div_ovf",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1, 1'b1, 2'd0};
        dir[8] = '{"mtlo",       3'd7, 32'h0000_1234, 32'hDEAD_BEEF, 64'h0000_0000_0000_1234, 1'b0, 1'b1, 2'd0};
        dir[9] = '{"mthi",       3'd6, 32'h0000_1234, 32'hDEAD_BEEF, 64'h0000_1234_0000_0000, 1'b1, 1'b0, 2'd0};

        Rst = 1'b1; Start = 1'b0; MdOp = 3'd0; A = '0; B = '0; trk_load = 1'b1;
        #3 Rst = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset/Busy,Done,RegWriteH,L", {60'b0, Busy, Done, RegWriteH, RegWriteL}, 64'd0);
        check("reset/WriteData", WriteData, 64'd0);
        check("reset/Op", {62'b0, Op}, 64'd3);
        @(negedge Clk);
        Rst = 1'b1;
        repeat (2) @(posedge Clk);

        for (int i = 0; i < 10; i++) apply_vec(dir[i]);

        // Accumulate sequence: HI/LO starts at 10, +2*3, -(-1*5) -> 21.
        @(negedge Clk); trk_load = 1'b1;
        @(negedge Clk); trk_load = 1'b0;
        apply_vec('{"madd", 3'd4, 32'd2,         32'd3, 64'd6,                   1'b0, 1'b0, 2'd1});
        apply_vec('{"msub", 3'd5, 32'hFFFF_FFFF, 32'd5, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b0, 2'd2});
        check("hilo_accumulate", hilo, 64'd21);

        // Start held high through the write cycle: second op accepted at the first edge in IDLE.
        @(negedge Clk);
        Start = 1'b1; MdOp = 3'd6; A = 32'hA5A5_0001;
        @(posedge Clk); #1;
        MdOp = 3'd7; A = 32'h0000_BEEF;
        done_pat = '0; wd1 = '0; wd3 = '0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge Clk); #1;
            done_pat[c-1] = Done;
            if (c == 1) wd1 = WriteData;
            if (c == 3) wd3 = WriteData;
            if (c == 2) Start = 1'b0;
        end
        check("b2b/done_pattern", {60'b0, done_pat}, 64'b0101);
        check("b2b/first_write", wd1, 64'hA5A5_0001_0000_0000);
        check("b2b/second_write", wd3, 64'h0000_0000_0000_BEEF);
        repeat (3) @(posedge Clk);

        // Abort: MULTU, ignored Start at cycle 5, reset at cycle 10.
        @(negedge Clk);
        Start = 1'b1; MdOp = 3'd1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        Start = 1'b1; MdOp = 3'd7; A = 32'h55;
        @(posedge Clk); #1;
        Start = 1'b0;
        check("ignored_start/Busy,Done,Op", {61'b0, Busy, Done, Op == 2'd3}, 64'b101);
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        check("abort/Busy,Done,RegWriteH,L", {60'b0, Busy, Done, RegWriteH, RegWriteL}, 64'd0);
        check("abort/WriteData", WriteData, 64'd0);
        check("abort/Op", {62'b0, Op}, 64'd3);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        done_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge Clk); #1;
            if (Done === 1'b1) done_seen = 1'b1;
        end
        check("abort/no_done_after_reset", {63'b0, done_seen}, 64'd0);
        apply_vec('{"divu_after_reset", 3'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b1, 1'b1, 2'd0});

        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(1, 15);
                default: ;
            endcase
            model(3'($urandom_range(0, 7)), ra, rb, rv);
            apply_vec(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
